// File: rtl/histo_pkg.sv
// ----------------------------------------------------------------------------
// histo_pkg : shared FSM types, marker constant and bin update function
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package histo_pkg;

  typedef enum logic [1:0] {
    SEQ_WAIT_INIT = 2'd0,
    SEQ_RUNNING   = 2'd1,
    SEQ_GAP       = 2'd2,
    SEQ_FINISHED  = 2'd3
  } seq_state_t;

  typedef enum logic [2:0] {
    ACC_IDLE  = 3'd0,
    ACC_READ  = 3'd1,
    ACC_WRITE = 3'd2,
    ACC_MARK  = 3'd3,
    ACC_HALT  = 3'd4
  } acc_state_t;

  localparam logic [31:0] DONE_MARKER = 32'hFFFF_FFFF;

  // Count field in [count_w-1:0], error field above it; each saturates on its own.
  function automatic logic [31:0] bin_update(input logic [31:0] word,
                                             input logic        err,
                                             input int unsigned count_w = 24);
    logic [31:0] cmask;
    logic [31:0] emax;
    logic [31:0] cnt;
    logic [31:0] errf;
    cmask = (32'd1 << count_w) - 32'd1;
    emax  = 32'hFFFF_FFFF >> count_w;
    cnt   = word & cmask;
    errf  = word >> count_w;
    if (cnt != cmask) cnt = cnt + 32'd1;
    if (err && (errf != emax)) errf = errf + 32'd1;
    return (errf << count_w) | cnt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/histogram_rmw.sv
// ----------------------------------------------------------------------------
// histogram_rmw : read-modify-write of one histogram bin per result, then marker
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module histogram_rmw
  import histo_pkg::*;
#(
  parameter int unsigned BIN_COUNT = 1024,
  parameter int unsigned COUNT_W   = 24,
  parameter int unsigned MEM_LAT   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic [31:0] i_duration,
  input  logic        i_error,
  input  logic        i_seq_finished,
  input  logic [31:0] i_mem_rdata,
  output logic        o_idle,
  output logic        o_done,
  output logic [3:0]  o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata
);

  localparam logic [31:0] c_LAST_BIN  = 32'(BIN_COUNT - 1);
  localparam logic [31:0] c_MARK_ADDR = 32'(BIN_COUNT * 4);
  localparam logic [1:0]  c_LAT_LAST  = 2'(MEM_LAT - 1);

  acc_state_t  r_state;
  logic [31:0] r_bin_addr;
  logic        r_err;
  logic [1:0]  r_lat;
  logic        r_done;

  logic [31:0] w_bin_idx;
  logic [31:0] w_bin_addr;

  assign w_bin_idx  = (i_duration > c_LAST_BIN) ? c_LAST_BIN : i_duration;
  assign w_bin_addr = w_bin_idx << 2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ACC_IDLE;
      r_bin_addr <= '0;
      r_err      <= 1'b0;
      r_lat      <= '0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        ACC_IDLE: begin
          if (i_start) begin
            r_bin_addr <= w_bin_addr;
            r_err      <= i_error;
            r_lat      <= '0;
            r_state    <= ACC_READ;
          end
        end
        ACC_READ: begin
          if (r_lat == c_LAT_LAST) r_state <= ACC_WRITE;
          else                     r_lat   <= r_lat + 2'd1;
        end
        ACC_WRITE: r_state <= i_seq_finished ? ACC_MARK : ACC_IDLE;
        ACC_MARK: begin
          r_state <= ACC_HALT;
          r_done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // rdata for the held address is valid during WRITE, so the update is formed there.
  always_comb begin
    o_mem_wdata = '0;
    case (r_state)
      ACC_WRITE: o_mem_wdata = bin_update(i_mem_rdata, r_err, COUNT_W);
      ACC_MARK:  o_mem_wdata = DONE_MARKER;
      default:   o_mem_wdata = '0;
    endcase
  end

  assign o_mem_we   = ((r_state == ACC_WRITE) || (r_state == ACC_MARK)) ? 4'b1111 : 4'b0000;
  assign o_mem_addr = (r_state == ACC_MARK) ? c_MARK_ADDR : r_bin_addr;
  assign o_idle     = (r_state == ACC_IDLE);
  assign o_done     = r_done;

endmodule

`default_nettype wire

// File: rtl/decoder_histogram_collector.sv
// ----------------------------------------------------------------------------
// decoder_histogram_collector : round sequencer plus latency histogram writer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module decoder_histogram_collector
  import histo_pkg::*;
#(
  parameter int unsigned NUM_RUNS     = 10000,
  parameter logic [31:0] STARTUP_WAIT = 32'hB000_0000,
  parameter int unsigned GAP_CYCLES   = 10,
  parameter int unsigned BIN_COUNT    = 1024,
  parameter int unsigned COUNT_W      = 24,
  parameter int unsigned ERR_W        = 8,
  parameter int unsigned MEM_LAT      = 1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        new_round_start,
  input  logic        result_valid,
  input  logic [31:0] duration,
  input  logic        error_detected,
  input  logic        downstream_busy,
  output logic [31:0] total_test_case_counter,
  output logic        done,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  if ((COUNT_W + ERR_W != 32) || (MEM_LAT < 1) || (MEM_LAT > 3)) begin : g_param_check
    $error("decoder_histogram_collector: COUNT_W+ERR_W must be 32 and MEM_LAT in 1..3");
  end

  seq_state_t  r_seq;
  logic [31:0] r_wait_cnt;
  logic [31:0] r_total;
  logic        r_pulse;
  logic        r_rv_d;

  logic [31:0] w_wait_inc;
  logic        w_edge;
  logic        w_acc_idle;
  logic        w_seq_finished;

  assign w_wait_inc     = (r_wait_cnt == '1) ? r_wait_cnt : r_wait_cnt + 32'd1;
  assign w_edge         = result_valid & ~r_rv_d & (r_seq == SEQ_RUNNING) & ~r_pulse;
  assign w_seq_finished = (r_seq == SEQ_FINISHED);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_seq      <= SEQ_WAIT_INIT;
      r_wait_cnt <= '0;
      r_total    <= '0;
      r_pulse    <= 1'b0;
      r_rv_d     <= 1'b0;
    end else begin
      r_rv_d  <= result_valid;
      r_pulse <= 1'b0;
      if (r_pulse) r_total <= r_total + 32'd1;
      case (r_seq)
        SEQ_WAIT_INIT: begin
          r_wait_cnt <= w_wait_inc;
          if ((r_wait_cnt >= STARTUP_WAIT) && !downstream_busy) begin
            r_seq   <= SEQ_RUNNING;
            r_pulse <= 1'b1;
          end
        end
        SEQ_RUNNING: begin
          r_wait_cnt <= '0;
          if (w_edge) r_seq <= (r_total < 32'(NUM_RUNS)) ? SEQ_GAP : SEQ_FINISHED;
        end
        SEQ_GAP: begin
          r_wait_cnt <= w_wait_inc;
          // Waiting for the accumulator keeps RMW operations strictly serial.
          if ((r_wait_cnt >= 32'(GAP_CYCLES)) && w_acc_idle && !downstream_busy) begin
            r_seq   <= SEQ_RUNNING;
            r_pulse <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  histogram_rmw #(
    .BIN_COUNT (BIN_COUNT),
    .COUNT_W   (COUNT_W),
    .MEM_LAT   (MEM_LAT)
  ) u_rmw (
    .clk            (clk),
    .reset          (reset),
    .i_start        (w_edge),
    .i_duration     (duration),
    .i_error        (error_detected),
    .i_seq_finished (w_seq_finished),
    .i_mem_rdata    (mem_rdata),
    .o_idle         (w_acc_idle),
    .o_done         (done),
    .o_mem_we       (mem_we),
    .o_mem_addr     (mem_addr),
    .o_mem_wdata    (mem_wdata)
  );

  assign new_round_start         = r_pulse;
  assign total_test_case_counter = r_total;
  assign mem_en                  = 1'b1;

endmodule

`default_nettype wire

// File: doc/decoder_histogram_collector.md
# decoder_histogram_collector

Parametrised test-run sequencer and latency histogram accumulator for the decoder benchmark harness. It waits for the startup interval, then issues a fixed number of decoding rounds. For each result it performs a read-modify-write on a BRAM-port histogram bin, counting both occurrences and logical errors per duration bin. After the last round it writes a completion marker, which the ARM host polls.

## Interface
Parameters:
- NUM_RUNS, 10000: rounds to issue before finishing.
- STARTUP_WAIT, 32'hB0000000: idle cycles after reset before the first round (about 30 s).
- GAP_CYCLES, 10: minimum cycles between a result and the next round start.
- BIN_COUNT, 1024: histogram bins; the last bin is the overflow bin.
- COUNT_W, 24: occurrence-count field width; occupies word bits [COUNT_W-1:0].
- ERR_W, 8: error-count field width; occupies the upper bits. COUNT_W+ERR_W must equal 32.
- MEM_LAT, 1: BRAM read latency in cycles (1..3).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- new_round_start  out  1  one-cycle pulse that starts a decoding round
- result_valid  in  1  level from the decoder; only its rising edge counts
- duration  in  32  decode latency in cycles; sampled on the result_valid rising edge
- error_detected  in  1  logical error flag; sampled with duration
- downstream_busy  in  1  blocks round starts while high
- total_test_case_counter  out  32  rounds issued so far
- done  out  1  high once the completion marker is written; sticky
- mem_en  out  1  tied to 1
- mem_we  out  4  byte write enables, either 4'b0000 or 4'b1111
- mem_addr  out  32  byte address
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data, valid MEM_LAT cycles after the address is presented

## Operation
Sequencer states are WAIT_INIT, RUNNING, GAP and FINISHED:
- WAIT_INIT: wait_cnt increments every cycle. When wait_cnt >= STARTUP_WAIT and !downstream_busy, go to RUNNING and pulse new_round_start.
- RUNNING: wait_cnt is cleared. On a qualified result edge, go to GAP if total_test_case_counter < NUM_RUNS, otherwise go to FINISHED.
- GAP: wait_cnt increments every cycle. Leave GAP only when all three hold: wait_cnt >= GAP_CYCLES, the accumulator is IDLE, and !downstream_busy. On exit, return to RUNNING and pulse new_round_start.
- FINISHED: terminal until reset.

Qualified result edge:
- Requires result_valid=1 with the previous cycle's value 0, state RUNNING, and new_round_start=0.
- Edges in any other state are ignored.
- On a qualified edge, duration and error_detected are latched into the accumulator.

Round counter: total_test_case_counter increments by 1 in the cycle after each new_round_start pulse.

Accumulator states are IDLE, READ, WRITE, MARK and HALT:
- Bin index = min(duration, BIN_COUNT-1). Bin address = index*4.
- IDLE to READ on a qualified edge. The bin address is held for MEM_LAT cycles, then rdata is captured.
- WRITE: one cycle with mem_we=4'b1111, writing the updated word:
  - count field: +1, saturating at all-ones.
  - error field: +error_detected, saturating at all-ones.
  - Each field saturates independently; no carry crosses between them.
- After WRITE: go to MARK if the sequencer is FINISHED, otherwise go to IDLE.
- MARK: one write of 32'hFFFFFFFF to byte address BIN_COUNT*4, a dedicated word that is never a bin. Then go to HALT and set done=1.
- HALT: mem_we=0 permanently until reset.
- In all states except WRITE and MARK: mem_we=0, mem_wdata=0, and mem_addr holds the current or last bin address.

## Timing
- Reset values: new_round_start=0, total_test_case_counter=0, done=0, mem_we=0, mem_addr=0, mem_wdata=0. Both FSMs reset to their first state.
- First pulse: new_round_start is registered and asserts 1 cycle after the first cycle in which the WAIT_INIT exit condition holds.
- Result-edge to write: the write occurs MEM_LAT+1 cycles after the cycle in which the edge is seen.
- GAP exit requires the accumulator to be IDLE, so RMW operations never overlap and no read-after-write forwarding is needed.
- Effective gap = max(GAP_CYCLES, MEM_LAT+2) cycles.
- result_valid held high across rounds counts once per low-to-high transition.
- downstream_busy asserted in the exit cycle delays the pulse until it drops. Counters keep running meanwhile.
- Reset mid-RMW: the pending write is abandoned. Memory contents are left untouched; clearing is the host's job.

## Structure
- Shared package histo_pkg holds:
  - seq_state_t and acc_state_t enums.
  - DONE_MARKER = 32'hFFFFFFFF.
  - function bin_update(word, err), which performs the saturating per-field increment, parametrised by COUNT_W.
- Sub-module histogram_rmw contains the accumulator FSM, the read-latency pipe, the saturating update and the marker write. The top level contains the sequencer, round counter and edge detect.
- Elaboration check fails if COUNT_W+ERR_W != 32 or MEM_LAT is outside 1..3.

## Test plan
- Startup: STARTUP_WAIT=20, downstream_busy=1 until cycle 30 -> first new_round_start at cycle 31, total_test_case_counter=1 one cycle later.
- Binning: NUM_RUNS=3, durations 5, 5, 7 with error_detected=0,1,0 -> addr 20 holds 32'h01000002 and addr 28 holds 32'h00000001. done rises after the marker write of 32'hFFFFFFFF at BIN_COUNT*4.
- Overflow bin: BIN_COUNT=16, duration=1000 -> the write goes to addr 60. No write occurs outside 0..64.
- Saturation: preload a bin with 32'hFFFFFFFF, error_detected=1 -> the word stays 32'hFFFFFFFF. Preload 32'h00FFFFFF, error_detected=1 -> 32'h01FFFFFF.
- Latency and gap: MEM_LAT=3, GAP_CYCLES=2 -> the write lands 4 cycles after the edge. The next round start comes no earlier than 5 cycles after the edge.
- Robustness: result_valid held high for 50 cycles -> exactly one bin update. Reset asserted during READ -> no write, all outputs at their reset values, and a full sequence runs correctly afterwards.
